p2_decode: RTL
==============

Name: p2_decode

Overview:
Second phase of the multi-cycle SIMPLE processor. It sits directly downstream of the fetch phase and consumes its latched instruction_register and program_counter. It decodes the instruction, reads the 8x16 general register file and produces latched operands, an immediate and control flags for the execute, memory and writeback phases. It also owns the register-file write port, which the writeback phase (state 3'b101) drives.

Parameters:
- REG_COUNT, 8, number of general registers (address width fixed at 3)
- DATA_WIDTH, 16, datapath width

Ports:
- clock  input  1  phase clock; all state updates on negedge, same as fetch
- reset  input  1  synchronous, active-low
- state  input  3  phase indicator; decode latches only when 3'b010
- instruction_register  input  16  IR from fetch
- program_counter  input  16  PC from fetch (already PC+1)
- wb_enable  input  1  writeback request
- wb_reg  input  3  writeback destination
- wb_data  input  16  writeback value
- operand_a  output  16  r[Rd] (arith), r[Ra] (LD/ST)
- operand_b  output  16  r[Rs] (arith), r[Rb] (LD/ST), imm (LI)
- immediate  output  16  sign-extended d field
- dest_reg  output  3  register to be written
- alu_op  output  4  op3 for arithmetic; 0000 (ADD) for LD/ST/branch address; 0110 (MOV) for LI
- reg_write  output  1  writeback required
- mem_read  output  1  LD
- mem_write  output  1  ST
- branch_uncond  output  1  B
- branch_cond  output  1  BE/BLT/BLE/BNE
- cond  output  3  condition code, IR[10:8]
- next_pc  output  16  latched program_counter for branch target
- io_in  output  1  IN
- io_out  output  1  OUT
- halt  output  1  HLT

Behaviour:
- Reset (reset==0 at negedge): every output is cleared to 0. All REG_COUNT registers are cleared to 0. Reset dominates state and wb_enable.
- Latching: on a negedge with state==3'b010, all outputs update from the combinational decode of instruction_register and the register-file read. Latency is one edge. In any other state, outputs hold.
- Register write: on a negedge with state==3'b101 and wb_enable==1, r[wb_reg] is set to wb_data. wb_enable is ignored in other states. Reads and writes never share a phase, so no bypass is needed.
- Decode, by op1 = IR[15:14]:
  - 11, arithmetic: Rs=IR[13:11], Rd=IR[10:8], op3=IR[7:4], d=IR[3:0].
  - reg_write=1 for ADD/SUB/AND/OR/XOR/MOV/SLL/SLR/SRL/SRA/IN. It is 0 for CMP/OUT/HLT.
  - Shift amount: immediate = zero-extended d.
  - op3 1100 sets io_in, 1101 sets io_out, 1111 sets halt. Undefined op3 (0111, 1110) decodes to a NOP: all flags 0.
  - 00, LD: Ra=IR[13:11] is the destination, Rb=IR[10:8]. immediate = sign-extended IR[7:0]. mem_read=1, reg_write=1, dest_reg=Ra.
  - 01, ST: operand_a = r[Ra] (store data), operand_b = r[Rb]. mem_write=1.
  - 10, with op2=IR[13:11]:
    - 000 LI: dest=IR[10:8], operand_b = immediate = sext(IR[7:0]), reg_write=1.
    - 100 B: branch_uncond=1.
    - 111: branch_cond=1, cond=IR[10:8]. cond values 100..111 decode to a NOP.
    - Other op2 values decode to a NOP.
- Sign extension replicates IR[7] into bits 15:8. Zero extension applies only to shift amounts.
- Exactly one of reg_write/mem_write/branch_*/halt/io_out may be 1 for any decode, with the sole exception of LD (mem_read and reg_write together).
- Reset asserted mid-phase, in any state, clears everything on that edge. The next decode after reset reads zeros.

Decomposition:
- Shared include file simple_defs.vh holds op1/op2/op3 encodings, cond codes and the state encodings 3'b001–3'b101. Fetch and later phases reuse it.
- One sub-module, register_file: 8x16 registers, two combinational read ports, one synchronous negedge write port and synchronous active-low clear. Decode logic stays in p2_decode.

Test Plan:
- Writeback r1=3 and r2=5 (state 101). Then IR=0xD100 (ADD R1,R2), state 010 -> operand_a=3, operand_b=5, alu_op=0000, dest_reg=1, reg_write=1.
- IR=0x83FE (LI R3,-2), state 010 -> immediate=0xFFFE, operand_b=0xFFFE, dest_reg=3, alu_op=0110, reg_write=1.
- r5=0x0100. IR=0x2504 (LD R4,4(R5)) -> operand_b=0x0100, immediate=0x0004, mem_read=1, reg_write=1, dest_reg=4.
- IR=0xA0FD (B -3) with program_counter=0x0011 -> branch_uncond=1, immediate=0xFFFD, next_pc=0x0011, reg_write=0.
- IR=0xC0F0 -> halt=1. Then change IR with state=3'b011 -> outputs unchanged. Then wb_enable=1 with state=3'b011 -> register unchanged.
- Load registers, assert reset=0 during state 010 -> all outputs 0. A subsequent read of r1..r7 returns 0.

Source files
------------

// File: rtl/p2_decode_pkg.sv
// Shared encodings and decode payload for the SIMPLE decode phase.
package p2_decode_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_N  = 8;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned ALU_W  = 4;

  localparam logic [2:0] ST_DECODE = 3'b010;
  localparam logic [2:0] ST_WB     = 3'b101;

  localparam logic [1:0] OP1_LD    = 2'b00;
  localparam logic [1:0] OP1_ST    = 2'b01;
  localparam logic [1:0] OP1_BR    = 2'b10;
  localparam logic [1:0] OP1_ARITH = 2'b11;

  localparam logic [2:0] OP2_LI = 3'b000;
  localparam logic [2:0] OP2_B  = 3'b100;
  localparam logic [2:0] OP2_BC = 3'b111;

  localparam logic [3:0] OP3_ADD  = 4'b0000;
  localparam logic [3:0] OP3_CMP  = 4'b0101;
  localparam logic [3:0] OP3_MOV  = 4'b0110;
  localparam logic [3:0] OP3_RSV0 = 4'b0111;
  localparam logic [3:0] OP3_IN   = 4'b1100;
  localparam logic [3:0] OP3_OUT  = 4'b1101;
  localparam logic [3:0] OP3_RSV1 = 4'b1110;
  localparam logic [3:0] OP3_HLT  = 4'b1111;

  // Highest defined branch condition (BE, BLT, BLE, BNE).
  localparam logic [2:0] COND_LAST = 3'b011;

  typedef struct packed {
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] immediate;
    logic [REG_AW-1:0] dest_reg;
    logic [ALU_W-1:0]  alu_op;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch_uncond;
    logic              branch_cond;
    logic [2:0]        cond;
    logic [DATA_W-1:0] next_pc;
    logic              io_in;
    logic              io_out;
    logic              halt;
  } dec_t;

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W - 8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/register_file.sv
// General register file: two combinational reads, one negedge write, sync clear.
module register_file #(
  parameter int unsigned REG_COUNT  = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            rd_addr_0,
  input  logic [2:0]            rd_addr_1,
  output logic [DATA_WIDTH-1:0] rd_data_0,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  input  logic                  wr_enable,
  input  logic [2:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  always_ff @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_enable) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_0 = regs[rd_addr_0];
  assign rd_data_1 = regs[rd_addr_1];

endmodule

// File: rtl/p2_decode.sv
// Decode phase: decodes IR, reads the register file and latches operands/flags.
module p2_decode
  import p2_decode_pkg::*;
#(
  parameter int unsigned REG_COUNT  = REG_N,
  parameter int unsigned DATA_WIDTH = DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            state,
  input  logic [15:0]           instruction_register,
  input  logic [DATA_WIDTH-1:0] program_counter,
  input  logic                  wb_enable,
  input  logic [2:0]            wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b,
  output logic [DATA_WIDTH-1:0] immediate,
  output logic [2:0]            dest_reg,
  output logic [3:0]            alu_op,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  branch_uncond,
  output logic                  branch_cond,
  output logic [2:0]            cond,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  io_in,
  output logic                  io_out,
  output logic                  halt
);

  logic [1:0]            op1;
  logic [2:0]            fld_hi;
  logic [2:0]            fld_lo;
  logic [3:0]            op3;
  logic [DATA_WIDTH-1:0] rf_lo;
  logic [DATA_WIDTH-1:0] rf_hi;
  dec_t                  dec;
  dec_t                  dec_q;

  assign op1    = instruction_register[15:14];
  assign fld_hi = instruction_register[13:11];
  assign fld_lo = instruction_register[10:8];
  assign op3    = instruction_register[7:4];

  register_file #(
    .REG_COUNT (REG_COUNT),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_register_file (
    .clock    (clock),
    .reset    (reset),
    .rd_addr_0(fld_lo),
    .rd_addr_1(fld_hi),
    .rd_data_0(rf_lo),
    .rd_data_1(rf_hi),
    .wr_enable(wb_enable && (state == ST_WB)),
    .wr_addr  (wb_reg),
    .wr_data  (wb_data)
  );

  // Any undefined encoding leaves the payload all-zero (a NOP) apart from next_pc.
  always_comb begin
    dec         = '0;
    dec.next_pc = program_counter;
    case (op1)
      OP1_ARITH: begin
        if (op3 != OP3_RSV0 && op3 != OP3_RSV1) begin
          dec.operand_a = rf_lo;
          dec.operand_b = rf_hi;
          dec.immediate = DATA_W'(instruction_register[3:0]);
          dec.alu_op    = op3;
          case (op3)
            OP3_CMP: ;
            OP3_OUT: dec.io_out = 1'b1;
            OP3_HLT: dec.halt   = 1'b1;
            default: begin
              dec.reg_write = 1'b1;
              dec.dest_reg  = fld_lo;
              dec.io_in     = (op3 == OP3_IN);
            end
          endcase
        end
      end
      OP1_LD: begin
        dec.operand_a = rf_hi;
        dec.operand_b = rf_lo;
        dec.immediate = sext8(instruction_register[7:0]);
        dec.alu_op    = OP3_ADD;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.dest_reg  = fld_hi;
      end
      OP1_ST: begin
        dec.operand_a = rf_hi;
        dec.operand_b = rf_lo;
        dec.immediate = sext8(instruction_register[7:0]);
        dec.alu_op    = OP3_ADD;
        dec.mem_write = 1'b1;
      end
      default: begin
        case (fld_hi)
          OP2_LI: begin
            dec.immediate = sext8(instruction_register[7:0]);
            dec.operand_b = sext8(instruction_register[7:0]);
            dec.alu_op    = OP3_MOV;
            dec.reg_write = 1'b1;
            dec.dest_reg  = fld_lo;
          end
          OP2_B: begin
            dec.immediate     = sext8(instruction_register[7:0]);
            dec.alu_op        = OP3_ADD;
            dec.branch_uncond = 1'b1;
          end
          OP2_BC: begin
            if (fld_lo <= COND_LAST) begin
              dec.immediate   = sext8(instruction_register[7:0]);
              dec.alu_op      = OP3_ADD;
              dec.branch_cond = 1'b1;
              dec.cond        = fld_lo;
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(negedge clock) begin
    if (!reset) dec_q <= '0;
    else if (state == ST_DECODE) dec_q <= dec;
  end

  assign operand_a     = dec_q.operand_a;
  assign operand_b     = dec_q.operand_b;
  assign immediate     = dec_q.immediate;
  assign dest_reg      = dec_q.dest_reg;
  assign alu_op        = dec_q.alu_op;
  assign reg_write     = dec_q.reg_write;
  assign mem_read      = dec_q.mem_read;
  assign mem_write     = dec_q.mem_write;
  assign branch_uncond = dec_q.branch_uncond;
  assign branch_cond   = dec_q.branch_cond;
  assign cond          = dec_q.cond;
  assign next_pc       = dec_q.next_pc;
  assign io_in         = dec_q.io_in;
  assign io_out        = dec_q.io_out;
  assign halt          = dec_q.halt;

endmodule
